// File: rtl/seq_div16x8_if.sv
// Operand/result handshake bundle for the sequential 16/8 divider.
// master drives operands and out_ready; slave is the divider.
interface seq_div16x8_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div16x8.sv
// Restoring 16/8 divider, one quotient bit per cycle; result N=16-APPROX_LSBS edges after accept (1 for /0).
// Backpressure: result held in DONE until out_ready; in_ready low while an operation is in flight.
module seq_div16x8 #(
    parameter int APPROX_LSBS = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_div16x8_if.slave bus
);
    localparam int         N    = 16 - APPROX_LSBS;
    localparam logic [4:0] NCNT = 5'(N);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [15:0] sreg;
    logic [7:0]  rem;
    logic [7:0]  dsr;

    logic [8:0]  trial;
    logic [8:0]  diff;
    logic        ge;
    logic [7:0]  rem_nxt;
    logic [15:0] sreg_nxt;

    // sreg holds the shifted dividend in its low N bits; quotient bits enter at
    // the LSB as dividend bits leave at position N-1, so after N steps the low
    // N bits are q'.
    always_comb begin
        trial    = {rem, sreg[N-1]};
        diff     = trial - {1'b0, dsr};
        ge       = (trial >= {1'b0, dsr});
        rem_nxt  = ge ? diff[7:0] : trial[7:0];
        sreg_nxt = {sreg[14:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= 5'd0;
            sreg            <= 16'd0;
            rem             <= 8'd0;
            dsr             <= 8'd0;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.quotient    <= 16'd0;
            bus.remainder   <= 8'd0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        dsr          <= bus.divisor;
                        if (bus.divisor == 8'd0) begin
                            state           <= DONE;
                            bus.quotient    <= 16'hFFFF;
                            bus.remainder   <= bus.dividend[7:0];
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            cnt   <= NCNT;
                            rem   <= 8'd0;
                            sreg  <= bus.dividend >> APPROX_LSBS;
                        end
                    end
                end
                CALC: begin
                    rem  <= rem_nxt;
                    sreg <= sreg_nxt;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state           <= DONE;
                        bus.out_valid   <= 1'b1;
                        // Left shift drops the stale upper bits and zero-fills the skipped LSBs.
                        bus.quotient    <= sreg_nxt << APPROX_LSBS;
                        bus.remainder   <= rem_nxt;
                        bus.div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    // Divide-by-zero arrives here with out_valid still low; raise it one edge later.
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div16x8.sv
// Directed bench for seq_div16x8: exact build (K=0) and approximate build (K=4).
module tb_seq_div16x8;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   lat;

    seq_div16x8_if b0 ();
    seq_div16x8_if b4 ();

    seq_div16x8 #(.APPROX_LSBS(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    seq_div16x8 #(.APPROX_LSBS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_ir(input bit s);
        return 32'(s ? b4.in_ready : b0.in_ready);
    endfunction
    function automatic logic [31:0] get_ov(input bit s);
        return 32'(s ? b4.out_valid : b0.out_valid);
    endfunction
    function automatic logic [31:0] get_q(input bit s);
        return 32'(s ? b4.quotient : b0.quotient);
    endfunction
    function automatic logic [31:0] get_r(input bit s);
        return 32'(s ? b4.remainder : b0.remainder);
    endfunction
    function automatic logic [31:0] get_z(input bit s);
        return 32'(s ? b4.div_by_zero : b0.div_by_zero);
    endfunction

    task automatic drive_in(input bit s, input logic v, input logic [15:0] a, input logic [7:0] b);
        if (s) begin
            b4.in_valid = v; b4.dividend = a; b4.divisor = b;
        end else begin
            b0.in_valid = v; b0.dividend = a; b0.divisor = b;
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the accept edge.
    task automatic start_op(input bit s, input string tag, input logic [15:0] a, input logic [7:0] b);
        chk({tag, "_in_ready"}, get_ir(s), 32'd1);
        drive_in(s, 1'b1, a, b);
        @(posedge clk);
        #1;
        drive_in(s, 1'b0, 16'd0, 8'd0);
    endtask

    task automatic wait_done(input bit s, output int n);
        n = 0;
        while (get_ov(s) != 32'd1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic res(input bit s, input string tag, input int n, input int elat,
                       input logic [15:0] q, input logic [7:0] r, input logic z);
        chk({tag, "_lat"}, 32'(n), 32'(elat));
        chk({tag, "_q"},   get_q(s), 32'(q));
        chk({tag, "_r"},   get_r(s), 32'(r));
        chk({tag, "_dbz"}, get_z(s), 32'(z));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_in(1'b0, 1'b0, 16'd0, 8'd0);
        drive_in(1'b1, 1'b0, 16'd0, 8'd0);
        b0.out_ready = 1'b1;
        b4.out_ready = 1'b1;
        #12;
        chk("rst_ov", get_ov(0), 32'd0);
        chk("rst_q",  get_q(0),  32'd0);
        chk("rst_r",  get_r(0),  32'd0);
        chk("rst_z",  get_z(0),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic exact division
        start_op(0, "t1", 16'd1000, 8'd7);
        wait_done(0, lat);
        res(0, "t1", lat, 16, 16'd142, 8'd6, 1'b0);
        step();

        // Corner values, back-to-back
        start_op(0, "t2a", 16'd65535, 8'd1);
        wait_done(0, lat);
        res(0, "t2a", lat, 16, 16'd65535, 8'd0, 1'b0);
        step();
        start_op(0, "t2b", 16'd65535, 8'd255);
        wait_done(0, lat);
        res(0, "t2b", lat, 16, 16'd257, 8'd0, 1'b0);
        step();
        start_op(0, "t2c", 16'd5, 8'd9);
        wait_done(0, lat);
        res(0, "t2c", lat, 16, 16'd0, 8'd5, 1'b0);
        step();

        // Divide by zero
        start_op(0, "t3", 16'h04D2, 8'd0);
        wait_done(0, lat);
        res(0, "t3", lat, 1, 16'hFFFF, 8'hD2, 1'b1);
        step();

        // Backpressure with an ignored in_valid pulse
        b0.out_ready = 1'b0;
        start_op(0, "t4", 16'd1000, 8'd7);
        wait_done(0, lat);
        res(0, "t4", lat, 16, 16'd142, 8'd6, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) drive_in(0, 1'b1, 16'd9, 8'd3);
            if (i == 2) drive_in(0, 1'b0, 16'd0, 8'd0);
            step();
            chk("t4_hold_ov", get_ov(0), 32'd1);
            chk("t4_hold_q",  get_q(0),  32'd142);
            chk("t4_hold_r",  get_r(0),  32'd6);
            chk("t4_hold_ir", get_ir(0), 32'd0);
        end
        b0.out_ready = 1'b1;
        step();
        chk("t4_hand_ov", get_ov(0), 32'd0);
        chk("t4_hand_ir", get_ir(0), 32'd1);
        step();
        chk("t4_idle_ov", get_ov(0), 32'd0);

        // Reset mid-calculation
        start_op(0, "t5", 16'd40000, 8'd3);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ov", get_ov(0), 32'd0);
        chk("t5_rst_q",  get_q(0),  32'd0);
        chk("t5_rst_r",  get_r(0),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_nostale_ov", get_ov(0), 32'd0);
        end
        start_op(0, "t5b", 16'd40000, 8'd3);
        wait_done(0, lat);
        res(0, "t5b", lat, 16, 16'd13333, 8'd1, 1'b0);
        step();

        // Approximate build, K=4
        start_op(1, "t6", 16'd1000, 8'd7);
        wait_done(1, lat);
        res(1, "t6", lat, 12, 16'd128, 8'd6, 1'b0);
        chk("t6_qlsb", get_q(1) & 32'hF, 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
